// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi : multi-channel PWM generator sharing one phase counter.
//
// Every channel has a shadow duty (written through the wr_* port) and an
// active duty (used to shape the waveform). Shadow values move into the active
// registers at a period boundary, so a duty change never produces a torn
// period. The edge/center alignment mode is also latched only at a boundary.
//
// Ports
//   clock         in   single clock, all logic on its rising edge
//   reset         in   synchronous, active-high reset
//   enable        in   counter run enable; low holds the counter at 0
//   align_center  in   0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   wr_valid      in   duty write request
//   wr_ready      out  write accept (high whenever reset is low)
//   wr_chan       in   target channel index
//   wr_duty       in   duty in clock cycles (values above PERIOD saturate)
//   wr_err        out  one-cycle pulse after a write to a non-existent channel
//   pwm_out       out  registered PWM outputs, one per channel
//   period_start  out  registered pulse marking counter value 0
//
// Handshake: a write transfers on any rising edge where wr_valid and wr_ready
// are both high; wr_chan/wr_duty are sampled on that same edge. wr_ready does
// not depend on wr_valid, and nothing is ever held back once ready is high.
// -----------------------------------------------------------------------------
module pwm_multi #(
   parameter  int CHANNELS = 4,
   parameter  int PERIOD   = 100_000,
   localparam int DW       = $clog2(PERIOD + 1),
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                align_center,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [CHW-1:0]      wr_chan,
   input  logic [DW-1:0]       wr_duty,
   output logic                wr_err,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start
);

   localparam logic [DW-1:0]  LAST   = DW'(PERIOD - 1);
   localparam logic [DW-1:0]  PER    = DW'(PERIOD);
   // One extra bit so that CHANNELS itself is representable for the compare.
   localparam logic [CHW:0]   CH_LIM = (CHW + 1)'(CHANNELS);

   logic [DW-1:0]       c_q, c_d;
   logic                mode_q, mode_d;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                ps_q, ps_d;
   logic                err_q, err_d;

   logic                boundary;
   logic                accept;
   logic                chan_ok;
   logic [CHANNELS-1:0] wr_hit;

   logic [DW-1:0]       shadow_q [CHANNELS];
   logic [DW-1:0]       active_q [CHANNELS];

   // Ready is a pure function of reset so it can never wait on wr_valid.
   assign wr_ready = ~reset;
   assign accept   = wr_valid & wr_ready;
   assign chan_ok  = ({1'b0, wr_chan} < CH_LIM);

   // With enable low every cycle is a boundary, so active duties and mode
   // track their shadow/input continuously and are already in place on the
   // first enabled cycle.
   assign boundary = ~enable | (c_q == LAST);

   always_comb begin
      c_d = '0;
      if (enable && (c_q != LAST)) begin
         c_d = c_q + DW'(1);
      end
   end

   assign mode_d = boundary ? align_center : mode_q;
   assign ps_d   = enable & (c_q == '0);
   assign err_d  = accept & ~chan_ok;

   // -------------------------------------------------------------------------
   // Per-channel duty storage and waveform compare
   // -------------------------------------------------------------------------
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [DW-1:0] d_eff;
      logic [DW-1:0] start;
      logic [DW:0]   stop;

      assign wr_hit[g] = accept & chan_ok & (wr_chan == CHW'(g));

      always_ff @(posedge clock) begin
         if (reset) begin
            shadow_q[g] <= '0;
            active_q[g] <= '0;
         end else begin
            if (wr_hit[g]) begin
               shadow_q[g] <= wr_duty;
            end
            // A write landing on the boundary cycle bypasses the shadow so
            // it still takes effect for the very next period.
            if (boundary) begin
               active_q[g] <= wr_hit[g] ? wr_duty : shadow_q[g];
            end
         end
      end

      assign d_eff = (active_q[g] > PER) ? PER : active_q[g];
      // Center mode puts the high window in the middle; odd slack rounds the
      // start down, so the extra low cycle falls at the end of the period.
      assign start = (PER - d_eff) >> 1;
      assign stop  = {1'b0, start} + {1'b0, d_eff};

      assign pwm_d[g] = enable &
                        (mode_q ? ((c_q >= start) && ({1'b0, c_q} < stop))
                                : (c_q < d_eff));
   end

   // -------------------------------------------------------------------------
   // Shared state
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         c_q    <= '0;
         mode_q <= 1'b0;
         pwm_q  <= '0;
         ps_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         c_q    <= c_d;
         mode_q <= mode_d;
         pwm_q  <= pwm_d;
         ps_q   <= ps_d;
         err_q  <= err_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = ps_q;
   assign wr_err       = err_q;

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi : bench for pwm_multi with PERIOD=10.
// u_dut  : CHANNELS=4, checked every cycle against a behavioural model.
// u_dut3 : CHANNELS=3, used for the invalid-channel write.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

   localparam int P = 10;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // main DUT signals
   logic       en = 1'b0, ac = 1'b0, wv = 1'b0;
   logic [1:0] wc = '0;
   logic [3:0] wd = '0;
   logic       rdy, err, ps;
   logic [3:0] pwm;

   // three-channel DUT signals
   logic       en3 = 1'b0, wv3 = 1'b0;
   logic [1:0] wc3 = '0;
   logic [3:0] wd3 = '0;
   logic       rdy3, err3, ps3;
   logic [2:0] pwm3;

   pwm_multi #(.CHANNELS(4), .PERIOD(P)) u_dut (
      .clock(clk), .reset(rst), .enable(en), .align_center(ac),
      .wr_valid(wv), .wr_ready(rdy), .wr_chan(wc), .wr_duty(wd),
      .wr_err(err), .pwm_out(pwm), .period_start(ps)
   );

   pwm_multi #(.CHANNELS(3), .PERIOD(P)) u_dut3 (
      .clock(clk), .reset(rst), .enable(en3), .align_center(1'b0),
      .wr_valid(wv3), .wr_ready(rdy3), .wr_chan(wc3), .wr_duty(wd3),
      .wr_err(err3), .pwm_out(pwm3), .period_start(ps3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: phase value, shadow/active duties, mode
   // ---------------------------------------------------------------------------
   int         m_c = 0;
   logic [3:0] m_sh [4] = '{default: '0};
   logic [3:0] m_act[4] = '{default: '0};
   logic       m_mode = 1'b0;

   // Advance one clock: predict from the inputs now applied, then compare.
   task automatic step();
      logic [3:0] np;
      logic       nps, nerr, bnd, wok, nmode;
      logic [3:0] nsh [4];
      logic [3:0] nact[4];
      int         nc, d, s;
      np = '0; nps = 1'b0; nerr = 1'b0; nc = 0;
      nsh = m_sh; nact = m_act; nmode = m_mode;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin nsh[i] = '0; nact[i] = '0; end
         nmode = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            d = (int'(m_act[i]) > P) ? P : int'(m_act[i]);
            if (m_mode) begin
               s = (P - d) / 2;
               np[i] = en && (m_c >= s) && (m_c < s + d);
            end else begin
               np[i] = en && (m_c < d);
            end
         end
         nps  = en && (m_c == 0);
         bnd  = !en || (m_c == P - 1);
         wok  = wv;  // every 2-bit index names one of the 4 channels
         nerr = 1'b0;
         if (bnd) begin
            for (int i = 0; i < 4; i++) nact[i] = m_sh[i];
            nmode = ac;
         end
         if (wok) begin
            nsh[wc] = wd;
            if (bnd) nact[wc] = wd;
         end
         nc = en ? (m_c + 1) % P : 0;
      end
      @(posedge clk);
      #1;
      m_c = nc; m_sh = nsh; m_act = nact; m_mode = nmode;
      chk("pwm_out", 32'(pwm), 32'(np));
      chk("period_start", 32'(ps), 32'(nps));
      chk("wr_err", 32'(err), 32'(nerr));
      chk("wr_ready", 32'(rdy), 32'(!rst));
   endtask

   task automatic wait_c(input int k);
      for (int n = 0; n < 3 * P && m_c != k; n++) step();
      chk("wait_bound", 32'(m_c), 32'(k));
   endtask

   task automatic write(input logic [1:0] ch, input logic [3:0] duty);
      wv = 1'b1; wc = ch; wd = duty;
      step();
      wv = 1'b0;
   endtask

   task automatic count_ones(input int n, input int ch, output int ones);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (pwm[ch]) ones++;
      end
   endtask

   // Records one period of channel 0 starting at phase 0.
   task automatic record0(output logic [9:0] pat);
      pat = '0;
      for (int i = 0; i < P; i++) begin
         step();
         pat[i] = pwm[0];
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ones, ps_hits, ps_n, ones3, other3;
      logic [9:0] pat;

      // reset state
      for (int i = 0; i < 3; i++) step();
      chk("reset_pwm3", 32'(pwm3), 32'd0);
      chk("reset_rdy3", 32'(rdy3), 32'd0);
      rst = 1'b0;

      // invalid channel on the three-channel instance
      wv3 = 1'b1; wc3 = 2'd0; wd3 = 4'd5;
      step();
      wv3 = 1'b0;
      chk("err3_valid_write", 32'(err3), 32'd0);
      step();
      en3 = 1'b1;
      for (int i = 0; i < P; i++) step();
      wv3 = 1'b1; wc3 = 2'd3; wd3 = 4'd9;
      step();
      wv3 = 1'b0;
      chk("err3_pulse", 32'(err3), 32'd1);
      step();
      chk("err3_one_cycle", 32'(err3), 32'd0);
      ones3 = 0; other3 = 0;
      for (int i = 0; i < 2 * P; i++) begin
         step();
         if (pwm3[0]) ones3++;
         if (pwm3[2:1] != 2'b00) other3++;
      end
      chk("err3_ch0_duty_kept", 32'(ones3), 32'd10);
      chk("err3_others_kept", 32'(other3), 32'd0);
      chk("err3_quiet", 32'(err3), 32'd0);

      // duty 3 on ch0, edge mode
      write(2'd0, 4'd3);
      step();
      en = 1'b1;
      ones = 0; ps_n = 0; ps_hits = 0;
      for (int i = 0; i < 2 * P; i++) begin
         step();
         if (pwm[0]) ones++;
         if (ps) ps_n++;
         if (ps && pwm[0] && (i % P == 0)) ps_hits++;
      end
      chk("ch0_d3_high", 32'(ones), 32'd6);
      chk("ps_count", 32'(ps_n), 32'd2);
      chk("ps_with_rise", 32'(ps_hits), 32'd2);

      // duty 0 / full / saturated
      write(2'd1, 4'd0);
      write(2'd2, 4'd10);
      write(2'd3, 4'd15);
      for (int i = 0; i < 2 * P; i++) step();
      count_ones(P, 1, ones); chk("ch1_d0", 32'(ones), 32'd0);
      count_ones(P, 2, ones); chk("ch2_dfull", 32'(ones), 32'd10);
      count_ones(P, 3, ones); chk("ch3_dsat", 32'(ones), 32'd10);

      // mid-period write is held in the shadow until the wrap
      write(2'd1, 4'd5);
      wait_c(P - 1);
      step();
      count_ones(4, 1, ones);
      write(2'd1, 4'd2);
      if (pwm[1]) ones++;
      begin
         int rest;
         count_ones(5, 1, rest);
         chk("ch1_keep5", 32'(ones + rest), 32'd5);
      end
      count_ones(P, 1, ones);
      chk("ch1_next2", 32'(ones), 32'd2);

      // write on the boundary cycle forwards into the next period
      wait_c(P - 1);
      write(2'd0, 4'd7);
      count_ones(P, 0, ones);
      chk("ch0_fwd7", 32'(ones), 32'd7);

      // center alignment
      ac = 1'b1;
      write(2'd0, 4'd4);
      wait_c(P - 1);
      step();
      record0(pat);
      chk("center_d4", 32'(pat), 32'h078);
      write(2'd0, 4'd3);
      wait_c(P - 1);
      step();
      record0(pat);
      chk("center_d3", 32'(pat), 32'h038);
      pat = '0;
      for (int i = 0; i < P; i++) begin
         if (i == 5) ac = 1'b0;
         step();
         pat[i] = pwm[0];
      end
      chk("center_toggle_held", 32'(pat), 32'h038);
      record0(pat);
      chk("edge_after_wrap", 32'(pat), 32'h007);

      // reset mid-period while outputs are high
      wait_c(6);
      chk("pre_reset_high", 32'(pwm[2]), 32'd1);
      rst = 1'b1;
      step();
      chk("rst_pwm", 32'(pwm), 32'd0);
      chk("rst_rdy", 32'(rdy), 32'd0);
      rst = 1'b0;
      ones = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (pwm != 4'd0) ones++;
      end
      chk("post_reset_quiet", 32'(ones), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         en  = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 29) == 0) ac = ~ac;
         wv  = ($urandom_range(0, 9) < 3);
         wc  = 2'($urandom_range(0, 3));
         wd  = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0; wv = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
